// File: rtl/traffic_resp_kernel.sv
// traffic_resp_kernel: per-run request/response echo engine with programmable response latency.
// Latency: request accepted in cycle k (empty buffer) -> response valid in cycle k+1+t_ck_resp.
// Backpressure: req_ready_o drops while the buffer is full or the run quota is reached; a stalled
//               response holds rsp_valid_o/rsp_data_o until rsp_ready_i.
// Ports:
//   clk_i, rst_i                     clock, synchronous active-high reset
//   start_i, n_total_reqs_i,
//   t_ck_resp_i                      run start and run parameters (sampled in IDLE)
//   req_data_i/req_valid_i/req_ready_o   request stream sink
//   rsp_data_o/rsp_valid_o/rsp_ready_i   response stream source
//   done_o, ready_o, idle_o          run-completion pulse and status flags
module traffic_resp_kernel #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [31:0]       n_total_reqs_i,
  input  logic [31:0]       t_ck_resp_i,
  input  logic [DATA_W-1:0] req_data_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic              done_o,
  output logic              idle_o,
  output logic              ready_o
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        total_q, total_d;
  logic [31:0]        tck_q, tck_d;
  logic [31:0]        acc_cnt_q, acc_cnt_d;
  logic [31:0]        rsp_cnt_q, rsp_cnt_d;
  logic [31:0]        lat_q, lat_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   occ_q, occ_d;
  logic [DATA_W-1:0]  mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0]  mem_d [FIFO_DEPTH];

  logic in_run;
  logic fifo_full;
  logic fifo_empty;
  logic push;
  logic pop;
  logic new_head;

  // All handshake qualifiers come from registered state only.
  assign in_run      = (state_q == ST_RUN);
  assign fifo_full   = (occ_q == DEPTH_C);
  assign fifo_empty  = (occ_q == '0);
  assign req_ready_o = in_run && !fifo_full && (acc_cnt_q < total_q);
  assign rsp_valid_o = in_run && !fifo_empty && (lat_q == 32'd0);
  // Gate the data so it reads zero whenever no response is offered (reset value).
  assign rsp_data_o  = rsp_valid_o ? mem_q[rd_ptr_q] : '0;
  assign done_o      = (state_q == ST_DONE);
  assign ready_o     = (state_q == ST_DONE);
  assign idle_o      = (state_q == ST_IDLE);

  assign push = req_valid_i && req_ready_o;
  assign pop  = rsp_valid_o && rsp_ready_i;

  // A new entry reaches the head when pushing into an empty buffer, or when a pop
  // exposes either an older waiting entry or the entry pushed in the same cycle.
  assign new_head = (push && fifo_empty) || (pop && ((occ_q > CNT_W'(1)) || push));

  always_comb begin
    state_d   = state_q;
    total_d   = total_q;
    tck_d     = tck_q;
    acc_cnt_d = acc_cnt_q;
    rsp_cnt_d = rsp_cnt_q;
    lat_d     = lat_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    occ_d     = occ_q;
    mem_d     = mem_q;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          total_d   = n_total_reqs_i;
          tck_d     = t_ck_resp_i;
          acc_cnt_d = 32'd0;
          rsp_cnt_d = 32'd0;
          lat_d     = 32'd0;
          wr_ptr_d  = '0;
          rd_ptr_d  = '0;
          occ_d     = '0;
          state_d   = (n_total_reqs_i == 32'd0) ? ST_DONE : ST_RUN;
        end
      end

      ST_RUN: begin
        if (push) begin
          mem_d[wr_ptr_q] = req_data_i;
          wr_ptr_d        = wr_ptr_q + PTR_W'(1);
          acc_cnt_d       = acc_cnt_q + 32'd1;
        end
        if (pop) begin
          rd_ptr_d  = rd_ptr_q + PTR_W'(1);
          rsp_cnt_d = rsp_cnt_q + 32'd1;
        end
        case ({push, pop})
          2'b10:   occ_d = occ_q + CNT_W'(1);
          2'b01:   occ_d = occ_q - CNT_W'(1);
          default: occ_d = occ_q;
        endcase

        // Counter restarts for each fresh head, then counts down and parks at zero.
        if (new_head) begin
          lat_d = tck_q;
        end else if (lat_q != 32'd0) begin
          lat_d = lat_q - 32'd1;
        end

        if (pop && ((rsp_cnt_q + 32'd1) == total_q)) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      total_q   <= 32'd0;
      tck_q     <= 32'd0;
      acc_cnt_q <= 32'd0;
      rsp_cnt_q <= 32'd0;
      lat_q     <= 32'd0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      occ_q     <= '0;
    end else begin
      state_q   <= state_d;
      total_q   <= total_d;
      tck_q     <= tck_d;
      acc_cnt_q <= acc_cnt_d;
      rsp_cnt_q <= rsp_cnt_d;
      lat_q     <= lat_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      occ_q     <= occ_d;
    end
  end

  // Storage needs no reset: the occupancy flush makes old contents unreachable.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_traffic_resp_kernel.sv
// tb_traffic_resp_kernel: directed scenarios plus randomized runs checked cycle by cycle
// against a queue-based reference model of the echo/latency behaviour.
// Clock period 10; inputs driven 1 after the rising edge, outputs sampled on the falling edge.
module tb_traffic_resp_kernel;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          start_i;
  logic [31:0]   n_total_reqs_i;
  logic [31:0]   t_ck_resp_i;
  logic [DW-1:0] req_data_i;
  logic          req_valid_i;
  logic          req_ready_o;
  logic [DW-1:0] rsp_data_o;
  logic          rsp_valid_o;
  logic          rsp_ready_i;
  logic          done_o;
  logic          idle_o;
  logic          ready_o;

  traffic_resp_kernel #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .n_total_reqs_i (n_total_reqs_i),
    .t_ck_resp_i    (t_ck_resp_i),
    .req_data_i     (req_data_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .rsp_data_o     (rsp_data_o),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_ready_i    (rsp_ready_i),
    .done_o         (done_o),
    .idle_o         (idle_o),
    .ready_o        (ready_o)
  );

  always #5 clk_i = ~clk_i;

  int     n_cmp = 0;
  int     n_err = 0;
  longint cyc   = 0;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Reference model: phase 0=idle 1=running 2=done; a head entry becomes
  // visible t_ck cycles after the cycle in which it reached the head.
  int          m_mode;
  longint      m_total, m_tck, m_acc, m_served, m_head_since;
  logic [31:0] m_q[$];

  // Observations of the DUT used by directed scenario checks.
  int          obs_acc, obs_done;
  longint      first_push_cyc, vld_cyc, done_cyc, last_rsp_cyc;
  logic [31:0] obs_data[$];

  task automatic reset_obs();
    obs_acc        = 0;
    obs_done       = 0;
    first_push_cyc = -1;
    vld_cyc        = -1;
    done_cyc       = -1;
    last_rsp_cyc   = -1;
    obs_data.delete();
  endtask

  task automatic step(input logic rst, input logic st, input logic [31:0] ntot,
                      input logic [31:0] tck, input logic rv, input logic [31:0] rd,
                      input logic rr);
    logic        e_rdy, e_vld, e_push, e_pop, was_empty;
    logic [31:0] e_dat, dropped;
    rst_i          = rst;
    start_i        = st;
    n_total_reqs_i = ntot;
    t_ck_resp_i    = tck;
    req_valid_i    = rv;
    req_data_i     = rd;
    rsp_ready_i    = rr;
    @(negedge clk_i);
    e_rdy = (m_mode == 1) && (m_q.size() < DEPTH) && (m_acc < m_total);
    e_vld = (m_mode == 1) && (m_q.size() > 0) && (cyc >= m_head_since + m_tck);
    e_dat = e_vld ? m_q[0] : 32'd0;
    check_val("req_ready", req_ready_o, e_rdy);
    check_val("rsp_valid", rsp_valid_o, e_vld);
    check_val("rsp_data", rsp_data_o, e_dat);
    check_val("done", done_o, m_mode == 2);
    check_val("ready", ready_o, m_mode == 2);
    check_val("idle", idle_o, m_mode == 0);

    if (req_valid_i && req_ready_o) begin
      if (obs_acc == 0) first_push_cyc = cyc;
      obs_acc++;
    end
    if (rsp_valid_o && vld_cyc < 0) vld_cyc = cyc;
    if (rsp_valid_o && rsp_ready_i) begin
      obs_data.push_back(rsp_data_o);
      last_rsp_cyc = cyc;
    end
    if (done_o) begin
      obs_done++;
      done_cyc = cyc;
    end

    e_push = rv && e_rdy;
    e_pop  = e_vld && rr;
    if (rst) begin
      m_mode   = 0;
      m_acc    = 0;
      m_served = 0;
      m_q.delete();
    end else begin
      case (m_mode)
        0: if (st) begin
          m_total  = longint'(ntot);
          m_tck    = longint'(tck);
          m_acc    = 0;
          m_served = 0;
          m_q.delete();
          m_mode   = (ntot == 32'd0) ? 2 : 1;
        end
        1: begin
          was_empty = (m_q.size() == 0);
          if (e_pop) begin
            dropped = m_q.pop_front();
            m_served++;
          end
          if (e_push) begin
            m_q.push_back(rd);
            m_acc++;
          end
          if (e_pop || (e_push && was_empty)) m_head_since = cyc + 1;
          if (e_pop && m_served == m_total) m_mode = 2;
        end
        default: m_mode = 0;
      endcase
    end
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b1);
  endtask

  initial begin
    longint s_cyc;
    rst_i = 1'b1; start_i = 1'b0; n_total_reqs_i = '0; t_ck_resp_i = '0;
    req_valid_i = 1'b0; req_data_i = '0; rsp_ready_i = 1'b0;
    @(posedge clk_i); @(posedge clk_i); #1;
    m_mode = 0; m_acc = 0; m_served = 0; m_total = 0; m_tck = 0; m_head_since = 0;
    reset_obs();
    // Reset state, reset still held.
    step(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0);
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0);

    // Three back-to-back requests, zero latency.
    reset_obs();
    step(1'b0, 1'b1, 32'd3, 32'd0, 1'b0, 32'd0, 1'b1);
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 32'hA, 1'b1);
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 32'hB, 1'b1);
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 32'hC, 1'b1);
    idle_cycles(4);
    check_val("s1_acc", obs_acc, 3);
    check_val("s1_nrsp", obs_data.size(), 3);
    if (obs_data.size() == 3) begin
      check_val("s1_d0", obs_data[0], 32'hA);
      check_val("s1_d1", obs_data[1], 32'hB);
      check_val("s1_d2", obs_data[2], 32'hC);
    end
    check_val("s1_first_lat", vld_cyc - first_push_cyc, 1);
    check_val("s1_done_gap", done_cyc - last_rsp_cyc, 1);
    check_val("s1_done_cnt", obs_done, 1);

    // Single request, latency 5.
    reset_obs();
    step(1'b0, 1'b1, 32'd1, 32'd5, 1'b0, 32'd0, 1'b1);
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 32'h55, 1'b1);
    idle_cycles(10);
    check_val("s2_vld_delay", vld_cyc - first_push_cyc, 6);
    check_val("s2_done_delay", done_cyc - first_push_cyc, 7);
    check_val("s2_done_cnt", obs_done, 1);

    // Response backpressure with a full buffer, then drain.
    reset_obs();
    step(1'b0, 1'b1, 32'd8, 32'd1, 1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 32'h100 + obs_acc, 1'b0);
    check_val("s3_acc_stalled", obs_acc, 4);
    check_val("s3_ready_full", req_ready_o, 1'b0);
    for (int i = 0; i < 80 && obs_done == 0; i++)
      step(1'b0, 1'b0, 32'd0, 32'd0, obs_acc < 8, 32'h100 + obs_acc, 1'b1);
    check_val("s3_done_cnt", obs_done, 1);
    check_val("s3_acc", obs_acc, 8);
    check_val("s3_nrsp", obs_data.size(), 8);
    for (int i = 0; i < obs_data.size(); i++) check_val("s3_order", obs_data[i], 32'h100 + i);
    idle_cycles(1);

    // Zero-length run.
    reset_obs();
    s_cyc = cyc;
    step(1'b0, 1'b1, 32'd0, 32'd3, 1'b1, 32'h77, 1'b1);
    idle_cycles(3);
    check_val("s4_done_delay", done_cyc - s_cyc, 1);
    check_val("s4_acc", obs_acc, 0);
    check_val("s4_done_cnt", obs_done, 1);

    // Quota limits acceptance; start pulses during the run are ignored.
    reset_obs();
    step(1'b0, 1'b1, 32'd2, 32'd0, 1'b0, 32'd0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, i < 3, 32'd9, 32'd4, 1'b1, 32'h200 + i, 1'b1);
    idle_cycles(3);
    check_val("s5_acc", obs_acc, 2);
    check_val("s5_nrsp", obs_data.size(), 2);
    check_val("s5_done_cnt", obs_done, 1);

    // Reset mid-run, then a clean run.
    reset_obs();
    step(1'b0, 1'b1, 32'd4, 32'd3, 1'b0, 32'd0, 1'b0);
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 32'h301, 1'b0);
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 32'h302, 1'b0);
    check_val("s6_acc_pre", obs_acc, 2);
    step(1'b1, 1'b0, 32'd0, 32'd0, 1'b1, 32'h303, 1'b1);
    check_val("s6_idle_after_rst", idle_o, 1'b1);
    check_val("s6_vld_after_rst", rsp_valid_o, 1'b0);
    idle_cycles(8);
    check_val("s6_no_done", obs_done, 0);
    reset_obs();
    step(1'b0, 1'b1, 32'd2, 32'd1, 1'b0, 32'd0, 1'b1);
    for (int i = 0; i < 30 && obs_done == 0; i++)
      step(1'b0, 1'b0, 32'd0, 32'd0, obs_acc < 2, 32'h400 + obs_acc, 1'b1);
    check_val("s6_rerun_done", obs_done, 1);
    check_val("s6_rerun_nrsp", obs_data.size(), 2);
    if (obs_data.size() == 2) check_val("s6_rerun_d1", obs_data[1], 32'h401);
    idle_cycles(1);

    // Randomized runs, checked every cycle against the model.
    for (int r = 0; r < 40; r++) begin
      logic [31:0] nt, tk;
      int          budget;
      nt = $urandom_range(0, 9);
      tk = $urandom_range(0, 6);
      step(1'b0, 1'b1, nt, tk, 1'b0, 32'd0, 1'b0);
      budget = 400;
      while (m_mode != 0 && budget > 0) begin
        step(($urandom_range(0, 299) == 0), ($urandom_range(0, 9) == 0), $urandom, $urandom,
             ($urandom_range(0, 9) < 7), $urandom, ($urandom_range(0, 9) < 6));
        budget--;
      end
      check_val("rand_run_ends", m_mode == 0, 1'b1);
      idle_cycles($urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
